// File: rtl/game_timer_ctrl.sv
// rtl/game_timer_ctrl.sv - round countdown controller with pause, bonus time, warning and time-up pulse
module game_timer_ctrl #(
    parameter int START_SEC = 60,
    parameter int BONUS_SEC = 5,
    parameter int WARN_SEC  = 10
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       one_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       bonus,
    input  logic       stop,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       paused,
    output logic       warning,
    output logic       time_up
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] START_V = 7'(START_SEC);
    localparam logic [6:0] BONUS_V = 7'(BONUS_SEC);
    localparam logic [6:0] WARN_V  = 7'(WARN_SEC);
    localparam logic [6:0] MAX_V   = 7'd99;

    state_t     state_q, state_d;
    logic [6:0] remain_q, remain_d;
    logic       time_up_d;
    logic [7:0] sum;
    logic [6:0] added;

    // Bonus saturates at 99 before any tick decrement is applied.
    always_comb begin
        sum   = {1'b0, remain_q} + {1'b0, BONUS_V};
        added = remain_q;
        if (bonus) begin
            added = (sum > 8'd99) ? MAX_V : sum[6:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        time_up_d = 1'b0;
        if (stop) begin
            state_d  = IDLE;
            remain_d = START_V;
        end else if (start) begin
            state_d  = RUN;
            remain_d = START_V;
        end else if (pause) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end else if (state_q == PAUSE) begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (one_sec) begin
                        remain_d = added - 7'd1;
                        if (added == 7'd1) begin
                            state_d   = DONE;
                            time_up_d = 1'b1;
                        end
                    end else begin
                        remain_d = added;
                    end
                end
                PAUSE:   remain_d = added;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            remain_q <= START_V;
            time_up  <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            time_up  <= time_up_d;
        end
    end

    assign sec_tens = 4'(remain_q / 7'd10);
    assign sec_ones = 4'(remain_q % 7'd10);
    assign running  = (state_q == RUN);
    assign paused   = (state_q == PAUSE);
    assign warning  = ((state_q == RUN) || (state_q == PAUSE)) &&
                      (remain_q >= 7'd1) && (remain_q <= WARN_V);

endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb/tb_game_timer_ctrl.sv - self-checking bench for game_timer_ctrl against a behavioural model
module tb_game_timer_ctrl;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       one_sec = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       bonus = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] sec_tens, sec_ones;
    logic       running, paused, warning, time_up;

    int errors = 0;
    int checks = 0;

    // Model: mode is one of the named values below, remaining seconds as a plain int.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_mode;
    int m_remain;
    bit m_tu;
    int tu_count;

    game_timer_ctrl #(.START_SEC(60), .BONUS_SEC(5), .WARN_SEC(10)) dut (
        .clk(clk), .resetN(resetN), .one_sec(one_sec), .start(start), .pause(pause),
        .bonus(bonus), .stop(stop), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .paused(paused), .warning(warning), .time_up(time_up)
    );

    always #5 clk = ~clk;

    function automatic int min99(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    function automatic logic [11:0] exp_out();
        logic w;
        w = ((m_mode == M_RUN) || (m_mode == M_PAUSE)) && (m_remain >= 1) && (m_remain <= 10);
        return {4'(m_remain / 10), 4'(m_remain % 10), m_mode == M_RUN, m_mode == M_PAUSE, w, m_tu};
    endfunction

    function automatic logic [11:0] got();
        return {sec_tens, sec_ones, running, paused, warning, time_up};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_remain = 60; m_tu = 0;
    endtask

    task automatic model_step(input bit s_stop, s_start, s_pause, s_bonus, s_tick);
        m_tu = 0;
        if (s_stop) begin
            m_mode = M_IDLE; m_remain = 60;
        end else if (s_start) begin
            m_mode = M_RUN; m_remain = 60;
        end else if (s_pause) begin
            if (m_mode == M_RUN) m_mode = M_PAUSE;
            else if (m_mode == M_PAUSE) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            m_remain = min99(m_remain + (s_bonus ? 5 : 0)) - (s_tick ? 1 : 0);
            if (m_remain == 0) begin
                m_mode = M_DONE; m_tu = 1;
            end
        end else if (m_mode == M_PAUSE && s_bonus) begin
            m_remain = min99(m_remain + 5);
        end
    endtask

    // Drive one cycle of commands, let the edge happen, then sample 1 time unit later.
    task automatic apply(input bit s_stop, s_start, s_pause, s_bonus, s_tick);
        stop = s_stop; start = s_start; pause = s_pause; bonus = s_bonus; one_sec = s_tick;
        @(posedge clk);
        model_step(s_stop, s_start, s_pause, s_bonus, s_tick);
        #1;
        stop = 0; start = 0; pause = 0; bonus = 0; one_sec = 0;
        if (time_up === 1'b1) tu_count++;
    endtask

    task automatic test_reset();
        resetN = 0;
        model_reset();
        #12;
        checks++;
        if (got() !== exp_out()) begin
            errors++; $display("FAIL reset got=%h exp=%h", got(), exp_out());
        end
        @(negedge clk) resetN = 1;
        apply(0, 1, 0, 0, 0);
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL reset_start running got=%b exp=1", running);
        end
    endtask

    task automatic test_countdown();
        tu_count = 0;
        for (int i = 0; i < 60; i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                apply(0, 0, 0, 0, 0);
                checks++;
                if (got() !== exp_out()) begin
                    errors++; $display("FAIL countdown_gap got=%h exp=%h", got(), exp_out());
                end
            end
            apply(0, 0, 0, 0, 1);
            checks++;
            if (got() !== exp_out()) begin
                errors++; $display("FAIL countdown tick=%0d got=%h exp=%h", i, got(), exp_out());
            end
            if (m_remain == 10) begin
                checks++;
                if (warning !== 1'b1) begin
                    errors++; $display("FAIL warning_rise got=%b exp=1", warning);
                end
            end
        end
        apply(0, 0, 0, 0, 1);
        checks++;
        if (got() !== exp_out() || tu_count != 1) begin
            errors++; $display("FAIL done_hold got=%h exp=%h time_up_pulses=%0d exp=1", got(), exp_out(), tu_count);
        end
    endtask

    task automatic test_pause();
        apply(0, 1, 0, 0, 0);
        for (int i = 0; i < 18; i++) apply(0, 0, 0, 0, 1);
        apply(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 0, 1);
            checks++;
            if (got() !== exp_out() || {sec_tens, sec_ones} !== 8'h42) begin
                errors++; $display("FAIL pause_hold got=%h exp=%h", got(), exp_out());
            end
        end
        apply(0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 1);
        checks++;
        if (got() !== exp_out() || {sec_tens, sec_ones} !== 8'h41) begin
            errors++; $display("FAIL resume got=%h exp=%h", got(), exp_out());
        end
    endtask

    task automatic test_bonus();
        apply(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) apply(0, 0, 0, 1, 0);
        apply(0, 0, 0, 1, 0);
        checks++;
        if (got() !== exp_out() || {sec_tens, sec_ones} !== 8'h99) begin
            errors++; $display("FAIL bonus_sat got=%h exp=%h", got(), exp_out());
        end
        apply(0, 0, 0, 1, 1);
        checks++;
        if (got() !== exp_out() || {sec_tens, sec_ones} !== 8'h98) begin
            errors++; $display("FAIL bonus_tick_99 got=%h exp=%h", got(), exp_out());
        end
        while (m_remain > 1) apply(0, 0, 0, 0, 1);
        apply(0, 0, 0, 1, 1);
        checks++;
        if (got() !== exp_out() || {sec_tens, sec_ones, running, time_up} !== 10'b0000_0101_1_0) begin
            errors++; $display("FAIL bonus_tick_at_1 got=%h exp=%h", got(), exp_out());
        end
    endtask

    task automatic test_priority();
        apply(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 1);
        apply(1, 1, 1, 1, 1);
        checks++;
        if (got() !== exp_out() || {sec_tens, sec_ones, running} !== 9'b0110_0000_0) begin
            errors++; $display("FAIL stop_start got=%h exp=%h", got(), exp_out());
        end
        apply(0, 1, 0, 0, 0);
        for (int i = 0; i < 48; i++) apply(0, 0, 0, 0, 1);
        apply(0, 0, 1, 0, 0);
        apply(0, 1, 1, 1, 1);
        checks++;
        if (got() !== exp_out() || {sec_tens, sec_ones, running} !== 9'b0110_0000_1) begin
            errors++; $display("FAIL restart_from_pause got=%h exp=%h", got(), exp_out());
        end
    endtask

    task automatic test_reset_mid();
        tu_count = 0;
        apply(0, 1, 0, 0, 0);
        for (int i = 0; i < 57; i++) apply(0, 0, 0, 0, 1);
        resetN = 0;
        model_reset();
        #1;
        checks++;
        if (got() !== exp_out()) begin
            errors++; $display("FAIL reset_mid got=%h exp=%h", got(), exp_out());
        end
        @(negedge clk) resetN = 1;
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, $urandom_range(0, 1), 1);
            checks++;
            if (got() !== exp_out() || tu_count != 0) begin
                errors++; $display("FAIL idle_ticks got=%h exp=%h time_up_pulses=%0d", got(), exp_out(), tu_count);
            end
        end
        apply(0, 1, 0, 0, 0);
        for (int i = 0; i < 60; i++) apply(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, $urandom_range(0, 1), 1);
            checks++;
            if (got() !== exp_out() || {sec_tens, sec_ones} !== 8'h00) begin
                errors++; $display("FAIL done_ticks got=%h exp=%h", got(), exp_out());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 199) < 2, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 45);
            checks++;
            if (got() !== exp_out()) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got(), exp_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_bonus();
        test_priority();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
